// File: rtl/byte_serializer_if.sv
// Byte-in / bit-out handshake bundle for byte_serializer.
// slave = serializer side, master = producer/consumer side.
interface byte_serializer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in;
    logic             bit_out;
    logic             bit_valid;
    logic             bit_last;
    logic             out_ready;
    logic             busy;

    modport slave (
        input  in_valid, in, out_ready,
        output in_ready, bit_out, bit_valid, bit_last, busy
    );

    modport master (
        output in_valid, in, out_ready,
        input  in_ready, bit_out, bit_valid, bit_last, busy
    );
endinterface

// File: rtl/byte_serializer.sv
// Parallel word to serial bit stream. Optional trailing even-parity bit
// when BYTE_SERIALIZER_PARITY_EN is defined.
module byte_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    byte_serializer_if.slave   bus,
    output logic [1:0]         state_o
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
`ifdef BYTE_SERIALIZER_PARITY_EN
    localparam logic [1:0] S_PARITY = 2'd2;
`endif

    // Handshakes: a word transfers when in_valid && in_ready; a bit transfers
    // when bit_valid && out_ready. Outputs hold stable while out_ready is low.
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_data;
    logic             data_bit;
    logic             accept;
    logic             consume;
`ifdef BYTE_SERIALIZER_PARITY_EN
    logic             par_q, par_d;
`endif

    assign last_data = (state_q == S_SHIFT) && (cnt_q == CW'(WIDTH - 1));
    assign data_bit  = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];

    assign bus.bit_valid = (state_q != S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
`ifdef BYTE_SERIALIZER_PARITY_EN
    assign bus.bit_last = (state_q == S_PARITY);
    assign bus.bit_out  = (state_q == S_PARITY) ? par_q :
                          (state_q == S_SHIFT)  ? data_bit : 1'b0;
`else
    assign bus.bit_last = last_data;
    assign bus.bit_out  = (state_q == S_SHIFT) ? data_bit : 1'b0;
`endif
    assign bus.in_ready = (state_q == S_IDLE) || (bus.bit_last && bus.out_ready);

    assign accept  = bus.in_valid && bus.in_ready;
    assign consume = bus.bit_valid && bus.out_ready;
    assign state_o = state_q;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef BYTE_SERIALIZER_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_SHIFT: begin
                if (consume) begin
                    shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
                    cnt_d   = cnt_q + CW'(1);
                    if (last_data) begin
`ifdef BYTE_SERIALIZER_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_IDLE;
`endif
                    end
                end
            end
`ifdef BYTE_SERIALIZER_PARITY_EN
            S_PARITY: begin
                if (consume) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
        // Acceptance only happens in IDLE or on the consumed final bit, so it
        // overrides the frame-end transition to give zero-gap frames.
        if (accept) begin
            state_d = S_SHIFT;
            shreg_d = bus.in;
            cnt_d   = '0;
`ifdef BYTE_SERIALIZER_PARITY_EN
            par_d   = ^bus.in;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef BYTE_SERIALIZER_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_q <= 1'b0;
        else        par_q <= par_d;
    end
`endif
endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench for byte_serializer: LSB-first and MSB-first instances,
// with or without BYTE_SERIALIZER_PARITY_EN.
module tb_byte_serializer;
`ifdef BYTE_SERIALIZER_PARITY_EN
    localparam int FLEN = 9;
`else
    localparam int FLEN = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] st1, st2;
    int         n_checks = 0;
    int         n_fail   = 0;

    byte_serializer_if #(.WIDTH(8)) bus1 ();
    byte_serializer_if #(.WIDTH(8)) bus2 ();

    byte_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .state_o(st1));
    byte_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .state_o(st2));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " in_ready"},  32'(bus1.in_ready),  32'd1);
        check({tag, " bit_valid"}, 32'(bus1.bit_valid), 32'd0);
        check({tag, " bit_last"},  32'(bus1.bit_last),  32'd0);
        check({tag, " bit_out"},   32'(bus1.bit_out),   32'd0);
        check({tag, " busy"},      32'(bus1.busy),      32'd0);
    endtask

    // seq[i] is the i-th data bit expected on the wire; par is the parity bit.
    task automatic run_frame(input string tag, input logic [7:0] w, input logic [7:0] seq,
                             input logic par, input int stall_at, input int stall_len);
        logic eb;
        bus1.in_valid = 1'b1;
        bus1.in       = w;
        tick();
        bus1.in_valid = 1'b0;
        for (int i = 0; i < FLEN; i++) begin
            eb = (i < 8) ? seq[i] : par;
            if (i == stall_at) begin
                bus1.out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    check($sformatf("%s stall%0d bit", tag, s),   32'(bus1.bit_out),   32'(eb));
                    check($sformatf("%s stall%0d valid", tag, s), 32'(bus1.bit_valid), 32'd1);
                    check($sformatf("%s stall%0d last", tag, s),  32'(bus1.bit_last),  32'd0);
                    check($sformatf("%s stall%0d rdy", tag, s),   32'(bus1.in_ready),  32'd0);
                    tick();
                end
                bus1.out_ready = 1'b1;
            end
            check($sformatf("%s b%0d bit", tag, i),   32'(bus1.bit_out),   32'(eb));
            check($sformatf("%s b%0d valid", tag, i), 32'(bus1.bit_valid), 32'd1);
            check($sformatf("%s b%0d last", tag, i),  32'(bus1.bit_last),  32'(i == FLEN - 1));
            check($sformatf("%s b%0d rdy", tag, i),   32'(bus1.in_ready),  32'(i == FLEN - 1));
            check($sformatf("%s b%0d busy", tag, i),  32'(bus1.busy),      32'd1);
            tick();
        end
        check_idle({tag, " after"});
    endtask

    initial begin
        logic [7:0] seqs [2];
        logic       pars [2];
        logic       eb;
        int         f, j;

        rst_n          = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in        = '0;
        bus1.out_ready = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.in        = '0;
        bus2.out_ready = 1'b1;
        #1;
        check_idle("in reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_idle("post reset");
        check("msb post reset busy", 32'(bus2.busy), 32'd0);

        // 0x05 LSB-first: 1,0,1,0,0,0,0,0; parity of 0x05 is 0.
        run_frame("w05", 8'h05, 8'b0000_0101, 1'b0, -1, 0);

        // 0xA5: 1,0,1,0,0,1,0,1 with a 3-cycle stall on bit 2; parity 0.
        run_frame("wA5", 8'hA5, 8'b1010_0101, 1'b0, 2, 3);

        // Back-to-back 0xFF then 0x01 with no gap.
        seqs[0] = 8'hFF; pars[0] = 1'b0;
        seqs[1] = 8'h01; pars[1] = 1'b1;
        bus1.in_valid = 1'b1;
        bus1.in       = 8'hFF;
        tick();
        bus1.in = 8'h01;
        for (int i = 0; i < 2 * FLEN; i++) begin
            f  = i / FLEN;
            j  = i % FLEN;
            eb = (j < 8) ? seqs[f][j] : pars[f];
            check($sformatf("b2b %0d bit", i),   32'(bus1.bit_out),   32'(eb));
            check($sformatf("b2b %0d valid", i), 32'(bus1.bit_valid), 32'd1);
            check($sformatf("b2b %0d last", i),  32'(bus1.bit_last),  32'(j == FLEN - 1));
            check($sformatf("b2b %0d rdy", i),   32'(bus1.in_ready),  32'(j == FLEN - 1));
            tick();
            if (i == FLEN - 1) bus1.in_valid = 1'b0;
        end
        check_idle("b2b after");

        // MSB-first: 0x80 gives 1 then seven 0s; parity 1.
        bus2.in_valid = 1'b1;
        bus2.in       = 8'h80;
        tick();
        bus2.in_valid = 1'b0;
        for (int i = 0; i < FLEN; i++) begin
            eb = (i == 0) || (i == 8);
            check($sformatf("msb b%0d bit", i),  32'(bus2.bit_out),  32'(eb));
            check($sformatf("msb b%0d last", i), 32'(bus2.bit_last), 32'(i == FLEN - 1));
            tick();
        end
        check("msb after valid", 32'(bus2.bit_valid), 32'd0);
        check("msb after busy",  32'(bus2.busy),      32'd0);

        // Mid-frame reset after 3 bits of 0xFF.
        bus1.in_valid = 1'b1;
        bus1.in       = 8'hFF;
        tick();
        bus1.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("abort b%0d bit", i), 32'(bus1.bit_out), 32'd1);
            tick();
        end
        check("abort pre busy", 32'(bus1.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_idle("abort async");
        tick();
        rst_n = 1'b1;
        tick();
        check_idle("abort released");
        tick();
        check_idle("abort settled");

`ifdef BYTE_SERIALIZER_PARITY_EN
        // 0x07: 1,1,1,0,0,0,0,0 then parity 1; 0x03 parity 0.
        run_frame("par07", 8'h07, 8'b0000_0111, 1'b1, -1, 0);
        run_frame("par03", 8'h03, 8'b0000_0011, 1'b0, -1, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
